// File: rtl/imem_server.sv
`default_nettype none
// =============================================================================
// imem_server : instruction memory with a valid/ready fetch port and a streaming
//               program-load port; fixed read latency, misalign/range flagging.
// Rev 1.0
// =============================================================================
module imem_server #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
   parameter int          LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_instr,
   output logic                  rsp_err,
   input  logic                  ld_start,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [31:0]           ld_data,
   input  logic                  ld_last,
   output logic                  ld_busy,
   output logic [DEPTH_LOG2:0]   ld_count,
   output logic                  ld_ovf
);

   localparam int          DEPTH       = 1 << DEPTH_LOG2;
   localparam logic [31:0] C_SPAN      = 32'(DEPTH * 4);
   localparam logic [2:0]  C_WAIT_INIT = 3'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                state_q,     state_d;
   logic [2:0]            cnt_q,       cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q,       idx_d;
   logic                  err_q,       err_d;
   logic [31:0]           rsp_instr_q, rsp_instr_d;
   logic                  rsp_err_q,   rsp_err_d;
   logic [DEPTH_LOG2:0]   ld_count_q,  ld_count_d;
   logic                  ld_ovf_q,    ld_ovf_d;

   logic [31:0] mem [DEPTH];

   logic [31:0]           off;
   logic                  req_err;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  req_fire;
   logic                  ld_fire;
   logic                  mem_we;

   assign off     = req_addr - BASE_ADDR;
   assign req_err = (req_addr[1:0] != 2'b00) || (off >= C_SPAN);
   assign req_idx = off[DEPTH_LOG2+1:2];

   // Gated by reset so the port reads 0 while reset is held, even though IDLE.
   assign req_ready = reset && (((state_q == IDLE) && !ld_start) ||
                                ((state_q == RESP) && rsp_ready));
   assign req_fire  = req_valid && req_ready;

   assign ld_ready  = (state_q == LOAD);
   assign ld_busy   = (state_q == LOAD);
   assign ld_fire   = ld_valid && ld_ready;
   assign mem_we    = ld_fire && !ld_count_q[DEPTH_LOG2];

   assign rsp_valid = (state_q == RESP);
   assign rsp_instr = rsp_instr_q;
   assign rsp_err   = rsp_err_q;
   assign ld_count  = ld_count_q;
   assign ld_ovf    = ld_ovf_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      err_d       = err_q;
      rsp_instr_d = rsp_instr_q;
      rsp_err_d   = rsp_err_q;
      ld_count_d  = ld_count_q;
      ld_ovf_d    = ld_ovf_q;

      if (req_fire) begin
         // Acceptance covers both IDLE and the back-to-back case in RESP.
         if (LATENCY == 1) begin
            state_d     = RESP;
            rsp_err_d   = req_err;
            rsp_instr_d = req_err ? 32'h0 : mem[req_idx];
         end else begin
            state_d = WAIT;
            cnt_d   = C_WAIT_INIT;
            idx_d   = req_idx;
            err_d   = req_err;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (ld_start) begin
                  state_d    = LOAD;
                  ld_count_d = '0;
                  ld_ovf_d   = 1'b0;
               end
            end
            LOAD: begin
               if (ld_fire) begin
                  if (ld_count_q[DEPTH_LOG2]) begin
                     ld_ovf_d = 1'b1;
                  end else begin
                     ld_count_d = ld_count_q + 1'b1;
                  end
                  if (ld_last) begin
                     state_d = IDLE;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 3'd1) begin
                  state_d     = RESP;
                  rsp_err_d   = err_q;
                  rsp_instr_d = err_q ? 32'h0 : mem[idx_q];
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         rsp_instr_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         ld_count_q  <= '0;
         ld_ovf_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         rsp_instr_q <= rsp_instr_d;
         rsp_err_q   <= rsp_err_d;
         ld_count_q  <= ld_count_d;
         ld_ovf_q    <= ld_ovf_d;
      end
   end

   // Program storage survives reset so a loaded image outlives a core restart.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[ld_count_q[DEPTH_LOG2-1:0]] <= ld_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_server.sv
`default_nettype none
// =============================================================================
// tb_imem_server : scoreboard bench over three configurations
//                  (latency 1; latency 3; depth 4 with latency 2).
// Rev 1.0
// =============================================================================
module tb_imem_server;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid [N];
   logic        req_ready [N];
   logic [31:0] req_addr  [N];
   logic        rsp_valid [N];
   logic        rsp_ready [N];
   logic [31:0] rsp_instr [N];
   logic        rsp_err   [N];
   logic        ld_start  [N];
   logic        ld_valid  [N];
   logic        ld_ready  [N];
   logic [31:0] ld_data   [N];
   logic        ld_last   [N];
   logic        ld_busy   [N];
   logic [10:0] ld_count  [N];
   logic        ld_ovf    [N];

   int          n_vec = 0;
   int          n_mis = 0;
   int          rsp_cnt [N];
   logic [32:0] exp_q [N][$];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int D = (g == 2) ? 2 : 10;
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
      logic [D:0] cnt_w;

      imem_server #(
         .DEPTH_LOG2 (D),
         .BASE_ADDR  (32'h0000_3000),
         .LATENCY    (L)
      ) u_dut (
         .clk       (clk),
         .reset     (rst_n),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_instr (rsp_instr[g]),
         .rsp_err   (rsp_err[g]),
         .ld_start  (ld_start[g]),
         .ld_valid  (ld_valid[g]),
         .ld_ready  (ld_ready[g]),
         .ld_data   (ld_data[g]),
         .ld_last   (ld_last[g]),
         .ld_busy   (ld_busy[g]),
         .ld_count  (cnt_w),
         .ld_ovf    (ld_ovf[g])
      );

      assign ld_count[g] = 11'(cnt_w);

      // Monitor: every consumed response is matched against the scoreboard.
      always @(negedge clk) begin
         if (rsp_valid[g] && rsp_ready[g]) begin
            if (exp_q[g].size() == 0) begin
               n_vec++;
               n_mis++;
               $display("FAIL rsp_unexpected[%0d]: got err=%b instr=%h, required no response",
                        g, rsp_err[g], rsp_instr[g]);
            end else begin
               logic [32:0] e;
               e = exp_q[g].pop_front();
               chk($sformatf("rsp[%0d]", g), {rsp_err[g], rsp_instr[g]}, e);
            end
            rsp_cnt[g]++;
         end
      end
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input int k);
      chk($sformatf("zero_ctl[%0d]", k),
          33'({req_ready[k], rsp_valid[k], rsp_err[k], ld_ready[k], ld_busy[k], ld_ovf[k]}), 33'h0);
      chk($sformatf("zero_instr[%0d]", k), 33'(rsp_instr[k]), 33'h0);
      chk($sformatf("zero_count[%0d]", k), 33'(ld_count[k]), 33'h0);
   endtask

   // Single fetch with rsp_ready high; checks acceptance-to-valid latency.
   task automatic fetch(input int k, input logic [31:0] a, input logic [32:0] e);
      int lat;
      bit got;
      req_valid[k] = 1'b1;
      req_addr[k]  = a;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[k]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk($sformatf("req_accept_timeout[%0d]", k), 33'(req_ready[k]), 33'h1);
         req_valid[k] = 1'b0;
         return;
      end
      exp_q[k].push_back(e);
      tick();
      req_valid[k] = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (rsp_valid[k]) break;
      end
      chk($sformatf("latency[%0d] @%h", k, a), 33'(lat), 33'(lat_of(k)));
      tick();
   endtask

   task automatic load(input int k, input logic [31:0] w [8], input int n);
      ld_start[k] = 1'b1;
      tick();
      ld_start[k] = 1'b0;
      for (int i = 0; i < n; i++) begin
         ld_valid[k] = 1'b1;
         ld_data[k]  = w[i];
         ld_last[k]  = (i == n - 1);
         @(negedge clk);
         if (i == 0) chk($sformatf("ld_busy_in_load[%0d]", k), 33'({ld_busy[k], ld_ready[k]}), 33'h3);
         tick();
      end
      ld_valid[k] = 1'b0;
      ld_last[k]  = 1'b0;
      @(negedge clk);
      chk($sformatf("ld_busy_after_last[%0d]", k), 33'(ld_busy[k]), 33'h0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] wv [8];
      logic [31:0] v;
      int          base;
      bit          got;

      for (int k = 0; k < N; k++) begin
         req_valid[k] = 1'b0;
         req_addr[k]  = 32'h0;
         rsp_ready[k] = 1'b1;
         ld_start[k]  = 1'b0;
         ld_valid[k]  = 1'b0;
         ld_data[k]   = 32'h0;
         ld_last[k]   = 1'b0;
         rsp_cnt[k]   = 0;
      end
      for (int i = 0; i < 8; i++) wv[i] = 32'h0;

      // Reset values while reset is held
      #12;
      chk_zero(0);
      chk_zero(2);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("req_ready_after_reset", 33'(req_ready[0]), 33'h1);
      tick();

      // Load then fetch
      wv[0] = 32'h3C01_0001;
      wv[1] = 32'h3421_0002;
      wv[2] = 32'h0000_000C;
      load(0, wv, 3);
      load(1, wv, 3);
      chk("ld_count_3", 33'(ld_count[0]), 33'd3);
      chk("ld_ovf_3", 33'(ld_ovf[0]), 33'h0);
      chk("ld_count_3_l3", 33'(ld_count[1]), 33'd3);
      fetch(0, 32'h3000, {1'b0, 32'h3C01_0001});
      fetch(0, 32'h3004, {1'b0, 32'h3421_0002});
      fetch(0, 32'h3008, {1'b0, 32'h0000_000C});
      fetch(1, 32'h3000, {1'b0, 32'h3C01_0001});
      fetch(1, 32'h3004, {1'b0, 32'h3421_0002});
      fetch(1, 32'h3008, {1'b0, 32'h0000_000C});

      // Back-to-back at latency 1
      for (int i = 0; i < 4; i++) wv[i] = 32'hA000_0000 + 32'(i);
      load(0, wv, 4);
      base = rsp_cnt[0];
      req_valid[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr[0] = 32'h3000 + 32'(4 * i);
         @(negedge clk);
         chk($sformatf("b2b_ready_%0d", i), 33'(req_ready[0]), 33'h1);
         v = 32'hA000_0000 + 32'(i);
         exp_q[0].push_back({1'b0, v});
         tick();
      end
      req_valid[0] = 1'b0;
      @(negedge clk);
      #1;
      chk("b2b_rsp_count", 33'(rsp_cnt[0] - base), 33'd4);
      tick();

      // Backpressure at latency 3
      rsp_ready[1] = 1'b0;
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h3004;
      @(negedge clk);
      chk("bp_accept", 33'(req_ready[1]), 33'h1);
      exp_q[1].push_back({1'b0, 32'h3421_0002});
      tick();
      req_valid[1] = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid[1]) begin
            got = 1'b1;
            break;
         end
      end
      chk("bp_rsp_seen", 33'(got), 33'h1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold_ctl_%0d", i), 33'({rsp_valid[1], req_ready[1]}), 33'h2);
         chk($sformatf("bp_hold_data_%0d", i), {rsp_err[1], rsp_instr[1]}, {1'b0, 32'h3421_0002});
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready[1] = 1'b1;
      base = rsp_cnt[1];
      tick();
      @(negedge clk);
      #1;
      chk("bp_one_consumed", 33'(rsp_cnt[1] - base), 33'd1);
      chk("bp_valid_drops", 33'(rsp_valid[1]), 33'h0);
      tick();

      // Error responses
      fetch(0, 32'h0000_3002, {1'b1, 32'h0});
      fetch(0, 32'h0000_2FFC, {1'b1, 32'h0});
      fetch(0, 32'h0000_4000, {1'b1, 32'h0});

      // Overflow on the depth-4 instance
      for (int i = 0; i < 6; i++) wv[i] = 32'hB000_0000 + 32'(i);
      load(2, wv, 6);
      chk("ovf_flag", 33'(ld_ovf[2]), 33'h1);
      chk("ovf_count", 33'(ld_count[2]), 33'd4);
      fetch(2, 32'h3000, {1'b0, 32'hB000_0000});
      fetch(2, 32'h3004, {1'b0, 32'hB000_0001});
      fetch(2, 32'h3008, {1'b0, 32'hB000_0002});
      fetch(2, 32'h300C, {1'b0, 32'hB000_0003});
      fetch(2, 32'h3010, {1'b1, 32'h0});

      // Reset while a latency-3 request sits in WAIT
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h3008;
      @(negedge clk);
      tick();
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("wait_state_ctl", 33'({rsp_valid[1], req_ready[1]}), 33'h0);
      #2 rst_n = 1'b0;
      #1;
      chk_zero(1);
      chk_zero(0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ctl", 33'({req_ready[1], rsp_valid[1]}), 33'h2);
      tick();
      fetch(1, 32'h3008, {1'b0, 32'h0000_000C});
      fetch(1, 32'h3000, {1'b0, 32'h3C01_0001});

      // ld_start wins over a simultaneous request in IDLE
      ld_start[0]  = 1'b1;
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h3004;
      @(negedge clk);
      chk("prio_req_ready", 33'(req_ready[0]), 33'h0);
      tick();
      ld_start[0]  = 1'b0;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("prio_in_load", 33'({ld_busy[0], req_ready[0], rsp_valid[0]}), 33'h4);
      tick();
      ld_valid[0] = 1'b1;
      ld_data[0]  = 32'hCAFE_0001;
      ld_last[0]  = 1'b1;
      tick();
      ld_valid[0] = 1'b0;
      ld_last[0]  = 1'b0;
      @(negedge clk);
      chk("prio_ld_count", 33'(ld_count[0]), 33'd1);
      chk("prio_ld_busy", 33'(ld_busy[0]), 33'h0);
      tick();
      fetch(0, 32'h3000, {1'b0, 32'hCAFE_0001});
      fetch(0, 32'h3004, {1'b0, 32'hA000_0001});

      repeat (3) tick();
      for (int k = 0; k < N; k++) begin
         chk($sformatf("scoreboard_empty[%0d]", k), 33'(exp_q[k].size()), 33'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
